// File: rtl/not_not_round_ctrl.sv
// NotNot round controller: sequences prompt refresh, draw, player response and scoring,
// and keeps the score, the high score and a shrinking per-round time limit.
module not_not_round_ctrl #(
  parameter int unsigned NUM_KEYS     = 4,
  parameter int unsigned SCORE_W      = 8,
  parameter int unsigned TIMER_W      = 28,
  parameter int unsigned TIMEOUT_BASE = 100000000,
  parameter int unsigned TIMEOUT_STEP = 2000000,
  parameter int unsigned TIMEOUT_MIN  = 25000000
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start_i,
  input  logic [NUM_KEYS-1:0] key_n_i,
  input  logic [NUM_KEYS-1:0] expected_i,
  input  logic                done_draw_i,
  output logic                lfsr_step_o,
  output logic                draw_start_o,
  output logic                draw_lose_o,
  output logic [SCORE_W-1:0]  score_o,
  output logic [SCORE_W-1:0]  highscore_o,
  output logic [TIMER_W-1:0]  round_timer_o,
  output logic [2:0]          state_o
);

  localparam int unsigned WideW = TIMER_W + SCORE_W + 1;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StRefresh = 3'd1,
    StDraw    = 3'd2,
    StPlay    = 3'd3,
    StLose    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_KEYS-1:0] sync1_q, sync2_q, prev_q, press;
  logic [NUM_KEYS-1:0] expected_q, expected_d;
  logic [SCORE_W-1:0]  score_q, score_d, high_q, high_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                draw_start_q;
  logic [WideW-1:0]    penalty, remaining, load;
  logic                one_press, multi_press, win, lose;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= StIdle;
      sync1_q      <= '1;
      sync2_q      <= '1;
      prev_q       <= '1;
      expected_q   <= '0;
      score_q      <= '0;
      high_q       <= '0;
      timer_q      <= '0;
      draw_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= key_n_i;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      expected_q   <= expected_d;
      score_q      <= score_d;
      high_q       <= high_d;
      timer_q      <= timer_d;
      // DRAW is only ever entered from REFRESH, so this marks its first cycle.
      draw_start_q <= (state_q == StRefresh);
    end
  end

  // Falling edge of the synchronized active-low keys.
  assign press       = prev_q & ~sync2_q;
  assign one_press   = ($countones(press) == 1);
  assign multi_press = ($countones(press) > 1);

  // Wide arithmetic so a large score cannot wrap the limit around.
  assign penalty   = WideW'(score_q) * WideW'(TIMEOUT_STEP);
  assign remaining = WideW'(TIMEOUT_BASE) - penalty;
  assign load      = ((penalty < WideW'(TIMEOUT_BASE)) && (remaining > WideW'(TIMEOUT_MIN)))
                     ? remaining : WideW'(TIMEOUT_MIN);

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    score_d    = score_q;
    high_d     = high_q;
    timer_d    = timer_q;
    win        = 1'b0;
    lose       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRefresh;
          score_d = '0;
        end
      end
      StRefresh: state_d = StDraw;
      StDraw: begin
        if (done_draw_i) begin
          state_d    = StPlay;
          expected_d = expected_i;
          timer_d    = load[TIMER_W-1:0];
        end
      end
      StPlay: begin
        if (timer_q != '0) timer_d = timer_q - TIMER_W'(1);
        if (multi_press) begin
          lose = 1'b1;
        end else if (one_press) begin
          if ((press & expected_q) != '0) win = 1'b1;
          else lose = 1'b1;
        end else if (timer_q == '0) begin
          if (expected_q == '0) win = 1'b1;
          else lose = 1'b1;
        end
      end
      StLose: begin
        if ((press != '0) || start_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (win) begin
      state_d = StRefresh;
      if (score_q != '1) score_d = score_q + SCORE_W'(1);
    end
    if (lose) begin
      state_d = StLose;
      if (score_q > high_q) high_d = score_q;
    end
  end

  assign lfsr_step_o   = (state_q == StRefresh);
  assign draw_start_o  = draw_start_q;
  assign draw_lose_o   = (state_q == StLose);
  assign score_o       = score_q;
  assign highscore_o   = high_q;
  assign round_timer_o = timer_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_not_not_round_ctrl.sv
// Randomized bench for not_not_round_ctrl: plays whole rounds and judges each one against a
// round-level model of the scoring, time-limit and lose rules.
module tb_not_not_round_ctrl;

  localparam int Base = 20;
  localparam int Step = 3;
  localparam int MinT = 8;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        done_draw = 1'b0;
  logic [3:0]  key_n = 4'hf;
  logic [3:0]  expected = 4'h0;
  logic        lfsr_step, draw_start, draw_lose;
  logic [3:0]  score, highscore;
  logic [27:0] round_timer;
  logic [2:0]  state;

  int n_checks = 0;
  int n_errors = 0;
  int m_score  = 0;
  int m_high   = 0;

  not_not_round_ctrl #(
    .NUM_KEYS    (4),
    .SCORE_W     (4),
    .TIMER_W     (28),
    .TIMEOUT_BASE(Base),
    .TIMEOUT_STEP(Step),
    .TIMEOUT_MIN (MinT)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .start_i      (start),
    .key_n_i      (key_n),
    .expected_i   (expected),
    .done_draw_i  (done_draw),
    .lfsr_step_o  (lfsr_step),
    .draw_start_o (draw_start),
    .draw_lose_o  (draw_lose),
    .score_o      (score),
    .highscore_o  (highscore),
    .round_timer_o(round_timer),
    .state_o      (state)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int load_for(input int s);
    int t;
    t = Base - s * Step;
    return (t < MinT) ? MinT : t;
  endfunction

  // Round outcome straight from the answer rules.
  function automatic bit judge(input logic [3:0] mask, input logic [3:0] keys);
    if (keys == 4'h0) return (mask == 4'h0);
    if ($countones(keys) > 1) return 1'b0;
    return ((keys & mask) != 4'h0);
  endfunction

  function automatic logic [3:0] pick_one(input logic [3:0] mask);
    int i;
    logic [3:0] r;
    i = $urandom_range(0, 3);
    while (!mask[i]) i = (i + 1) % 4;
    r = 4'h0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic start_game();
    check_eq("idle_before_start", 32'(state), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    m_score = 0;
    check_eq("start_refresh", 32'(state), 1);
    check_eq("start_score", 32'(score), 0);
    check_eq("start_high", 32'(highscore), m_high);
  endtask

  // Entered with the DUT in REFRESH; keys==0 means let the timer run out.
  task automatic run_round(input logic [3:0] mask, input logic [3:0] keys, input logic [3:0] hold,
                           input int draw_wait, input int delay, output bit won);
    int t;
    logic [27:0] held_timer;
    check_eq("refresh_state", 32'(state), 1);
    check_eq("lfsr_step", 32'(lfsr_step), 1);
    held_timer = round_timer;
    step();
    check_eq("draw_state", 32'(state), 2);
    check_eq("draw_start", 32'(draw_start), 1);
    check_eq("lfsr_once", 32'(lfsr_step), 0);
    check_eq("timer_hold", 32'(round_timer), 32'(held_timer));
    key_n = ~hold;
    for (int i = 0; i < draw_wait; i++) begin
      step();
      check_eq("draw_start_once", 32'(draw_start), 0);
      check_eq("draw_wait", 32'(state), 2);
    end
    expected = mask;
    done_draw = 1'b1;
    step();
    done_draw = 1'b0;
    expected = 4'($urandom);
    t = load_for(m_score);
    check_eq("play_state", 32'(state), 3);
    check_eq("timer_load", 32'(round_timer), t);
    if (keys != 4'h0) begin
      repeat (delay) step();
      key_n = ~(keys | hold);
      step();
      step();
      check_eq("timer_at_judge", 32'(round_timer), t - delay - 2);
      step();
    end else begin
      repeat (t) step();
      check_eq("timer_zero", 32'(round_timer), 0);
      check_eq("play_at_zero", 32'(state), 3);
      step();
    end
    key_n = 4'hf;
    won = judge(mask, keys);
    if (won) begin
      if (m_score < 15) m_score++;
      check_eq("win_state", 32'(state), 1);
    end else begin
      if (m_score > m_high) m_high = m_score;
      check_eq("lose_state", 32'(state), 4);
      check_eq("draw_lose", 32'(draw_lose), 1);
    end
    check_eq("score", 32'(score), m_score);
    check_eq("highscore", 32'(highscore), m_high);
  endtask

  task automatic leave_lose(input bit by_key);
    repeat (3) step();
    check_eq("lose_holds", 32'(state), 4);
    if (by_key) begin
      key_n[$urandom_range(0, 3)] = 1'b0;
      step();
      step();
      check_eq("lose_before_press", 32'(state), 4);
      step();
      key_n = 4'hf;
    end else begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    check_eq("lose_exit", 32'(state), 0);
    check_eq("draw_lose_off", 32'(draw_lose), 0);
    check_eq("score_held", 32'(score), m_score);
  endtask

  initial begin
    logic [3:0] mask, keys;
    bit won;
    int kind;

    repeat (2) step();
    check_eq("rst_state", 32'(state), 0);
    check_eq("rst_score", 32'(score), 0);
    check_eq("rst_high", 32'(highscore), 0);
    check_eq("rst_timer", 32'(round_timer), 0);
    check_eq("rst_outs", {29'd0, lfsr_step, draw_start, draw_lose}, 0);
    resetn = 1'b1;
    step();
    check_eq("idle_stays", 32'(state), 0);

    // Correct presses shrink the limit down to its floor.
    start_game();
    run_round(4'b0100, 4'b0100, 4'h0, 0, 0, won);
    for (int i = 0; i < 5; i++) begin
      mask = 4'($urandom_range(1, 15));
      run_round(mask, pick_one(mask), 4'h0, $urandom_range(0, 3), $urandom_range(0, 5), won);
    end
    run_round(4'b0000, 4'b0000, 4'h0, 1, 0, won);
    run_round(4'b0010, 4'b0000, 4'h0, 0, 0, won);
    leave_lose(1'b0);

    start_game();
    run_round(4'b1110, 4'b0001, 4'h0, 2, 3, won);
    leave_lose(1'b1);
    start_game();
    run_round(4'b1010, 4'b1010, 4'h0, 0, 1, won);
    leave_lose(1'b0);

    // Key already down before PLAY is not a press.
    start_game();
    run_round(4'b0010, 4'b0000, 4'b0010, 4, 0, won);
    leave_lose(1'b1);

    // Press judged on the very cycle the timer reads zero.
    start_game();
    run_round(4'b0010, 4'b0010, 4'h0, 1, load_for(0) - 2, won);

    for (int i = 0; i < 20; i++) begin
      mask = 4'($urandom_range(1, 15));
      run_round(mask, pick_one(mask), 4'h0, $urandom_range(0, 2),
                $urandom_range(0, load_for(m_score) - 2), won);
    end
    check_eq("saturated", 32'(score), 15);
    run_round(4'b0001, 4'b0010, 4'h0, 0, 0, won);
    leave_lose(1'b0);
    start_game();

    for (int r = 0; r < 30; r++) begin
      mask = 4'($urandom);
      kind = $urandom_range(0, 2);
      if (kind == 0) keys = 4'h0;
      else if (kind == 1 && mask != 4'h0) keys = pick_one(mask);
      else keys = 4'($urandom_range(1, 15));
      run_round(mask, keys, 4'h0, $urandom_range(0, 3),
                $urandom_range(0, load_for(m_score) - 2), won);
      if (!won) begin
        leave_lose(1'($urandom_range(0, 1)));
        start_game();
      end
    end

    // Reset in the middle of a round.
    check_eq("pre_rst_refresh", 32'(state), 1);
    step();
    done_draw = 1'b1;
    step();
    done_draw = 1'b0;
    check_eq("pre_rst_play", 32'(state), 3);
    repeat (2) step();
    resetn = 1'b0;
    step();
    check_eq("mid_rst_state", 32'(state), 0);
    check_eq("mid_rst_score", 32'(score), 0);
    check_eq("mid_rst_high", 32'(highscore), 0);
    check_eq("mid_rst_timer", 32'(round_timer), 0);
    check_eq("mid_rst_outs", {29'd0, lfsr_step, draw_start, draw_lose}, 0);
    resetn = 1'b1;
    m_score = 0;
    m_high = 0;
    step();
    start_game();
    run_round(4'b1000, 4'b1000, 4'h0, 0, 2, won);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
